// File: rtl/wino_pkg.sv
// Shared Winograd F(2x2,3x3) definitions: pixel width, tile size and the
// tile element-to-bit mapping used by both the tile feeder and the core.
package wino_pkg;
   localparam int PIX_W  = 8;
   localparam int TILE_N = 4;
   localparam int TILE_W = PIX_W * TILE_N * TILE_N;

   typedef logic [PIX_W-1:0] pix_t;
   // Window storage indexed [row][col], top-left = [0][0].
   typedef logic [TILE_N-1:0][TILE_N-1:0][PIX_W-1:0] win_t;

   function automatic int elem_lsb(input int i, input int j);
      return PIX_W * (TILE_N * i + j);
   endfunction

   function automatic logic [TILE_W-1:0] pack_tile(input win_t w);
      logic [TILE_W-1:0] t;
      t = {TILE_W{1'b0}};
      for (int i = 0; i < TILE_N; i++) begin
         for (int j = 0; j < TILE_N; j++) begin
            t[elem_lsb(i, j) +: PIX_W] = w[i][j];
         end
      end
      return t;
   endfunction
endpackage

// File: rtl/wino_tile_feeder_if.sv
// Pixel-in / tile-out handshake bundle of the Winograd tile feeder.
// tile_idx exists only when WINO_TILE_CNT_EN is defined.
interface wino_tile_feeder_if;
   import wino_pkg::*;

   pix_t              pix_in;
   logic              pix_valid;
   logic              pix_ready;
   logic [TILE_W-1:0] tile_out;
   logic              tile_valid;
   logic              tile_ready;
   logic              frame_done;
`ifdef WINO_TILE_CNT_EN
   logic [15:0]       tile_idx;

   modport slave  (input  pix_in, pix_valid, tile_ready,
                   output pix_ready, tile_out, tile_valid, frame_done, tile_idx);
   modport master (output pix_in, pix_valid, tile_ready,
                   input  pix_ready, tile_out, tile_valid, frame_done, tile_idx);
`else
   modport slave  (input  pix_in, pix_valid, tile_ready,
                   output pix_ready, tile_out, tile_valid, frame_done);
   modport master (output pix_in, pix_valid, tile_ready,
                   input  pix_ready, tile_out, tile_valid, frame_done);
`endif
endinterface

// File: rtl/wino_line_buf.sv
// Three cascaded IMG_W-deep shift rows; each tap is the pixel at the
// current column one, two and three rows above the incoming pixel.
module wino_line_buf
   import wino_pkg::*;
#(
   parameter int IMG_W = 16
) (
   input  logic clk,
   input  logic we,
   input  pix_t din,
   output pix_t tap1,
   output pix_t tap2,
   output pix_t tap3
);
   pix_t row0_r [IMG_W];
   pix_t row1_r [IMG_W];
   pix_t row2_r [IMG_W];

   // Shift all three rows by one pixel per accepted input.
   always_ff @(posedge clk) begin
      if (we) begin
         row0_r[0] <= din;
         row1_r[0] <= row0_r[IMG_W-1];
         row2_r[0] <= row1_r[IMG_W-1];
         for (int k = 1; k < IMG_W; k++) begin
            row0_r[k] <= row0_r[k-1];
            row1_r[k] <= row1_r[k-1];
            row2_r[k] <= row2_r[k-1];
         end
      end
   end

   assign tap1 = row0_r[IMG_W-1];
   assign tap2 = row1_r[IMG_W-1];
   assign tap3 = row2_r[IMG_W-1];
endmodule

// File: rtl/wino_tile_feeder.sv
// Raster pixel stream to stride-2 overlapping 4x4 tiles for a Winograd core.
// Optional feature: define WINO_TILE_CNT_EN to add the tile_idx output.
module wino_tile_feeder
   import wino_pkg::*;
#(
   parameter int IMG_W = 16,
   parameter int IMG_H = 16
) (
   input  logic clk,
   input  logic rst,
   wino_tile_feeder_if.slave bus
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_MIN  = CW'(TILE_N - 1);
   localparam logic [RW-1:0] ROW_MIN  = RW'(TILE_N - 1);

   logic [CW-1:0]     col_r;
   logic [RW-1:0]     row_r;
   win_t              win_r;
   win_t              win_nxt_s;
   pix_t              tap1_s, tap2_s, tap3_s;
   logic              pix_ready_s, accept_s, launch_s, last_s;
   logic [TILE_W-1:0] tile_out_r;
   logic              tile_valid_r;
   logic              frame_done_r;

   assign pix_ready_s = !tile_valid_r || bus.tile_ready;
   assign accept_s    = bus.pix_valid && pix_ready_s;

   wino_line_buf #(.IMG_W(IMG_W)) u_line_buf (
      .clk  (clk),
      .we   (accept_s),
      .din  (bus.pix_in),
      .tap1 (tap1_s),
      .tap2 (tap2_s),
      .tap3 (tap3_s)
   );

   // Tile bottoms sit on odd rows/cols from 3 up, which also keeps rows 0-2 of a frame out.
   always_comb begin
      launch_s = 1'b0;
      last_s   = 1'b0;
      if (accept_s) begin
         launch_s = (row_r >= ROW_MIN) && (col_r >= COL_MIN) && row_r[0] && col_r[0];
         last_s   = (row_r == ROW_LAST) && (col_r == COL_LAST);
      end else begin
         launch_s = 1'b0;
         last_s   = 1'b0;
      end
   end

   // Window after shifting in the accepted pixel's column.
   always_comb begin
      win_nxt_s = win_r;
      for (int i = 0; i < TILE_N; i++) begin
         for (int j = 0; j < TILE_N - 1; j++) begin
            win_nxt_s[i][j] = win_r[i][j+1];
         end
      end
      win_nxt_s[0][TILE_N-1] = tap3_s;
      win_nxt_s[1][TILE_N-1] = tap2_s;
      win_nxt_s[2][TILE_N-1] = tap1_s;
      win_nxt_s[3][TILE_N-1] = bus.pix_in;
   end

   // Raster position of the next pixel.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_r <= {CW{1'b0}};
         row_r <= {RW{1'b0}};
      end else if (accept_s) begin
         if (col_r == COL_LAST) begin
            col_r <= {CW{1'b0}};
            row_r <= (row_r == ROW_LAST) ? {RW{1'b0}} : row_r + RW'(1);
         end else begin
            col_r <= col_r + CW'(1);
         end
      end
   end

   // Sliding window; contents need no reset.
   always_ff @(posedge clk) begin
      if (accept_s) begin
         win_r <= win_nxt_s;
      end
   end

   // Tile output register and end-of-frame pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         tile_out_r   <= {TILE_W{1'b0}};
         tile_valid_r <= 1'b0;
         frame_done_r <= 1'b0;
      end else begin
         frame_done_r <= last_s;
         if (launch_s) begin
            tile_out_r   <= pack_tile(win_nxt_s);
            tile_valid_r <= 1'b1;
         end else if (bus.tile_ready) begin
            tile_valid_r <= 1'b0;
         end
      end
   end

   assign bus.pix_ready  = pix_ready_s;
   assign bus.tile_out   = tile_out_r;
   assign bus.tile_valid = tile_valid_r;
   assign bus.frame_done = frame_done_r;

`ifdef WINO_TILE_CNT_EN
   logic [15:0] next_idx_r;
   logic [15:0] tile_idx_r;

   // The last pixel of a frame always launches a tile, so the index restarts there.
   always_ff @(posedge clk) begin
      if (rst) begin
         next_idx_r <= 16'd0;
         tile_idx_r <= 16'd0;
      end else begin
         if (launch_s) begin
            tile_idx_r <= next_idx_r;
         end
         if (last_s) begin
            next_idx_r <= 16'd0;
         end else if (launch_s) begin
            next_idx_r <= next_idx_r + 16'd1;
         end
      end
   end

   assign bus.tile_idx = tile_idx_r;
`endif
endmodule

// File: tb/tb_wino_tile_feeder.sv
// Self-checking bench for wino_tile_feeder: 4x4, 6x6 and 16x16 instances
// checked against a tile list computed directly from the sent image.
module tb_wino_tile_feeder;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [7:0]   pix = 8'd0;
   logic         valid = 1'b0;
   logic         tready = 1'b1;
   logic [1:0]   sel = 2'd0;
   int           ready_mode = 0;
   bit           rand_gap = 1'b0;

   logic         pr, tv, fd;
   logic [127:0] tout;
   logic [15:0]  tidx;

   int           passed = 0;
   int           total = 0;
   int           fd_cnt = 0;
   logic [7:0]   img [16][16];
   logic [127:0] got_q [$];
   int           got_idx_q [$];
   logic [127:0] exp_q [$];

   typedef struct {
      int         idx;
      logic [7:0] tl;
      logic [7:0] br;
   } vec_t;
   vec_t vt [8];

   always #5 clk = ~clk;

   wino_tile_feeder_if bus4 ();
   wino_tile_feeder_if bus6 ();
   wino_tile_feeder_if bus16 ();

   wino_tile_feeder #(.IMG_W(4),  .IMG_H(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));
   wino_tile_feeder #(.IMG_W(6),  .IMG_H(6))  dut6  (.clk(clk), .rst(rst), .bus(bus6));
   wino_tile_feeder #(.IMG_W(16), .IMG_H(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

   assign bus4.pix_in      = pix;
   assign bus6.pix_in      = pix;
   assign bus16.pix_in     = pix;
   assign bus4.pix_valid   = valid && (sel == 2'd0);
   assign bus6.pix_valid   = valid && (sel == 2'd1);
   assign bus16.pix_valid  = valid && (sel == 2'd2);
   assign bus4.tile_ready  = (sel == 2'd0) ? tready : 1'b1;
   assign bus6.tile_ready  = (sel == 2'd1) ? tready : 1'b1;
   assign bus16.tile_ready = (sel == 2'd2) ? tready : 1'b1;

   always_comb begin
      tidx = 16'd0;
      case (sel)
         2'd0: begin
            pr = bus4.pix_ready; tv = bus4.tile_valid; tout = bus4.tile_out; fd = bus4.frame_done;
`ifdef WINO_TILE_CNT_EN
            tidx = bus4.tile_idx;
`endif
         end
         2'd1: begin
            pr = bus6.pix_ready; tv = bus6.tile_valid; tout = bus6.tile_out; fd = bus6.frame_done;
`ifdef WINO_TILE_CNT_EN
            tidx = bus6.tile_idx;
`endif
         end
         default: begin
            pr = bus16.pix_ready; tv = bus16.tile_valid; tout = bus16.tile_out; fd = bus16.frame_done;
`ifdef WINO_TILE_CNT_EN
            tidx = bus16.tile_idx;
`endif
         end
      endcase
   end

   // Downstream consumer: picks tile_ready, records tiles taken on the coming edge.
   always @(posedge clk) begin
      #2;
      case (ready_mode)
         0:       tready = 1'b1;
         1:       tready = 1'($urandom_range(0, 1));
         default: tready = 1'b0;
      endcase
      if (tv === 1'b1 && tready) begin
         got_q.push_back(tout);
         got_idx_q.push_back(int'(tidx));
      end
      if (fd === 1'b1) fd_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, required %0h", name, act, exp);
   endtask

   task automatic send(input logic [7:0] v);
      int n;
      if (rand_gap) repeat ($urandom_range(0, 2)) @(negedge clk);
      pix = v;
      valid = 1'b1;
      n = 0;
      while (pr !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         total++;
         $display("FAIL send_timeout: pix_ready=%b, required 1", pr);
      end
      @(posedge clk);
      @(negedge clk);
      valid = 1'b0;
   endtask

   // mode 0: pixel value = raster index, mode 1: random values.
   task automatic send_frame(input int w, input int h, input int mode, input int npix);
      logic [7:0] v;
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            if (r * w + c < npix) begin
               v = (mode == 0) ? 8'(r * w + c) : 8'($urandom);
               img[r][c] = v;
               send(v);
            end
         end
      end
   endtask

   // Every 4x4 block whose top-left sits on even coordinates, in raster order.
   task automatic add_exp(input int w, input int h);
      logic [127:0] t;
      for (int tr = 0; tr < h / 2 - 1; tr++) begin
         for (int tc = 0; tc < w / 2 - 1; tc++) begin
            for (int i = 0; i < 4; i++) begin
               for (int j = 0; j < 4; j++) begin
                  t[8 * (4 * i + j) +: 8] = img[2 * tr + i][2 * tc + j];
               end
            end
            exp_q.push_back(t);
         end
      end
   endtask

   task automatic compare_tiles(input string name);
      check({name, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
      for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
         check($sformatf("%s_tile%0d", name, k), got_q[k], exp_q[k]);
      end
   endtask

   task automatic check_table(input int n);
      for (int k = 0; k < n; k++) begin
         if (vt[k].idx < got_q.size()) begin
            check($sformatf("tbl_tl%0d", k), 128'(got_q[vt[k].idx][7:0]), 128'(vt[k].tl));
            check($sformatf("tbl_br%0d", k), 128'(got_q[vt[k].idx][127:120]), 128'(vt[k].br));
         end else begin
            check($sformatf("tbl_missing%0d", k), 128'(got_q.size()), 128'(vt[k].idx + 1));
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      got_q.delete();
      got_idx_q.delete();
      exp_q.delete();
      fd_cnt = 0;
   endtask

   task automatic drain();
      ready_mode = 0;
      repeat (5) @(negedge clk);
   endtask

   initial begin
      logic [127:0] t;
      logic [127:0] held;
      int           n;

      for (int k = 0; k < 8; k++) begin
         vt[k].idx = k;
         vt[k].tl  = 8'(((k % 4) / 2) * 12 + (k % 2) * 2);
         vt[k].br  = 8'(vt[k].tl + 8'd21);
      end

      // Reset state of every instance.
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int s = 0; s < 3; s++) begin
         sel = 2'(s);
         #1;
         check("rst_tile_valid", 128'(tv), 128'(1'b0));
         check("rst_frame_done", 128'(fd), 128'(1'b0));
         check("rst_tile_out", tout, 128'd0);
         check("rst_pix_ready", 128'(pr), 128'(1'b1));
`ifdef WINO_TILE_CNT_EN
         check("rst_tile_idx", 128'(tidx), 128'd0);
`endif
      end

      // 4x4: one tile holding 0..15, valid and frame_done one cycle after pixel 15.
      do_reset();
      sel = 2'd0;
      send_frame(4, 4, 0, 15);
      check("t4_no_early_tile", 128'(tv), 128'(1'b0));
      img[3][3] = 8'd15;
      send(8'd15);
      for (int k = 0; k < 16; k++) t[8 * k +: 8] = 8'(k);
      check("t4_tile_valid", 128'(tv), 128'(1'b1));
      check("t4_frame_done", 128'(fd), 128'(1'b1));
      check("t4_tile_out", tout, t);
      @(negedge clk);
      check("t4_frame_done_pulse", 128'(fd), 128'(1'b0));
      check("t4_tile_valid_clear", 128'(tv), 128'(1'b0));
      drain();
      add_exp(4, 4);
      compare_tiles("t4");
      check("t4_fd_count", 128'(fd_cnt), 128'd1);

      // 6x6 sequential frame.
      do_reset();
      sel = 2'd1;
      send_frame(6, 6, 0, 36);
      drain();
      add_exp(6, 6);
      compare_tiles("t6");
      check_table(4);
      check("t6_fd_count", 128'(fd_cnt), 128'd1);

      // Backpressure: first tile held for 10 cycles.
      do_reset();
      sel = 2'd1;
      ready_mode = 2;
      held = 128'd0;
      fork
         send_frame(6, 6, 0, 36);
         begin
            n = 0;
            while (tv !== 1'b1 && n < 500) begin
               @(negedge clk);
               n++;
            end
            if (n >= 500) check("bp_wait_tile", 128'(tv), 128'(1'b1));
            held = tout;
            repeat (10) begin
               @(negedge clk);
               check("bp_pix_ready", 128'(pr), 128'(1'b0));
               check("bp_hold", tout, held);
            end
            ready_mode = 0;
         end
      join
      drain();
      add_exp(6, 6);
      check("bp_held_tile", held, exp_q[0]);
      compare_tiles("bp");
      check("bp_fd_count", 128'(fd_cnt), 128'd1);

      // Back-to-back frames.
      do_reset();
      sel = 2'd1;
      send_frame(6, 6, 0, 36);
      add_exp(6, 6);
      send_frame(6, 6, 0, 36);
      add_exp(6, 6);
      drain();
      compare_tiles("b2b");
      check_table(8);
      check("b2b_fd_count", 128'(fd_cnt), 128'd2);

      // Reset after 20 pixels, then a full random frame.
      do_reset();
      sel = 2'd1;
      send_frame(6, 6, 1, 20);
      check("abort_no_tile", 128'(got_q.size()), 128'd0);
      do_reset();
      #1;
      check("abort_tile_valid", 128'(tv), 128'(1'b0));
      check("abort_pix_ready", 128'(pr), 128'(1'b1));
      send_frame(6, 6, 1, 36);
      drain();
      add_exp(6, 6);
      compare_tiles("abort");
      check("abort_fd_count", 128'(fd_cnt), 128'd1);

      // Random 6x6 frames with input gaps and random tile_ready.
      do_reset();
      sel = 2'd1;
      ready_mode = 1;
      rand_gap = 1'b1;
      for (int f = 0; f < 3; f++) begin
         send_frame(6, 6, 1, 36);
         add_exp(6, 6);
      end
      rand_gap = 1'b0;
      drain();
      compare_tiles("rnd6");
      check("rnd6_fd_count", 128'(fd_cnt), 128'd3);

      // 16x16: 49 tiles per frame, two frames.
      do_reset();
      sel = 2'd2;
      ready_mode = 1;
      for (int f = 0; f < 2; f++) begin
         send_frame(16, 16, 1, 256);
         add_exp(16, 16);
      end
      drain();
      compare_tiles("t16");
      check("t16_fd_count", 128'(fd_cnt), 128'd2);
`ifdef WINO_TILE_CNT_EN
      for (int k = 0; k < got_idx_q.size(); k++) begin
         check($sformatf("t16_idx%0d", k), 128'(got_idx_q[k]), 128'(k % 49));
      end
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/wino_tile_feeder.md
WINO_TILE_FEEDER -- requirements
Module: wino_tile_feeder

Interface
REQ-001 SHALL have parameter IMG_W, default 16: feature-map width in pixels; even, >= 4.
REQ-002 SHALL have parameter IMG_H, default 16: feature-map height in pixels; even, >= 4.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port pix_in, input, 8 bits: raster-order input pixel.
REQ-006 SHALL have port pix_valid, input, 1 bit: pix_in is valid.
REQ-007 SHALL have port pix_ready, output, 1 bit: the block accepts pix_in this cycle.
REQ-008 SHALL have port tile_out, output, 128 bits: 4x4 tile; element (i,j), row i and column j (0..3, top-left = 0,0), at bits [8*(4*i+j)+7 : 8*(4*i+j)].
REQ-009 SHALL have port tile_valid, output, 1 bit: tile_out holds an unconsumed tile.
REQ-010 SHALL have port tile_ready, input, 1 bit: the downstream Winograd F(2x2,3x3) core takes the tile.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle pulse marking end of frame.

Function
REQ-012 SHALL define a pixel as accepted when pix_valid && pix_ready on a rising edge.
REQ-013 SHALL drive pix_ready = !tile_valid || tile_ready (combinational).
REQ-014 SHALL keep counters col (0..IMG_W-1) and row (0..IMG_H-1) of the next pixel; they advance only on accept.
- col wraps to 0 after IMG_W-1, and row then increments.
- Both wrap to 0 after the last pixel of the frame.
REQ-015 SHALL store the three previous rows in line buffers and maintain a 4x4 sliding window that shifts one column left per accepted pixel.
- The new right column is {rows row-3, row-2, row-1 at col; pix_in}.
REQ-016 SHALL launch a tile when the accepted pixel has row >= 3, col >= 3, row odd and col odd.
- This gives stride-2 overlapping tiles: (IMG_W/2-1)*(IMG_H/2-1) tiles per frame.
REQ-017 SHALL register the launched tile into tile_out and set tile_valid on the next edge; latency is 1 cycle from accept.
REQ-018 SHALL clear tile_valid on the edge where tile_valid && tile_ready, unless a new tile launches on that same edge, in which case tile_valid stays 1 and tile_out updates.
REQ-019 SHALL hold tile_out stable while tile_valid && !tile_ready.
REQ-020 SHALL pulse frame_done for exactly one cycle, on the cycle after the last pixel of the frame (row IMG_H-1, col IMG_W-1) is accepted.
REQ-021 SHALL pass pixel data unmodified; no arithmetic and no sign handling on pixels.
REQ-022 SHALL NOT emit tiles containing data from the previous frame; rows 0-2 of each new frame are never tile bottoms.

Reset
REQ-023 SHALL, on rst, clear row, col, tile_valid and frame_done to 0; tile_out resets to 0.
REQ-024 SHALL treat rst mid-frame as an abort: the next accepted pixel is pixel (0,0) of a new frame.
REQ-025 SHALL not require line-buffer or window contents to be reset.

Configuration
REQ-026 SHALL, with macro WINO_TILE_CNT_EN defined, add port tile_idx, output, 16 bits: index of the tile on tile_out.
- Index counts from 0 within the frame and returns to 0 at the frame's first tile.
- tile_idx is cleared by rst and is stable with tile_out.
REQ-027 SHALL, without WINO_TILE_CNT_EN, have neither the tile_idx port nor its counter.

Structure
REQ-028 SHALL take PIX_W=8, TILE_N=4 and the tile element-to-bit mapping from shared package wino_pkg, which the Winograd core also uses.
REQ-029 SHALL instantiate one sub-module, wino_line_buf: a 3-row, IMG_W-deep shift line buffer with a write enable on accept.

Verification
REQ-030 SHALL check IMG_W=IMG_H=4, pixels 0..15 with tile_ready=1: exactly one tile, element (i,j) = 4i+j, tile_valid 1 cycle after pixel 15, and frame_done in that same cycle.
REQ-031 SHALL check IMG_W=IMG_H=6, pixels 0..35: 4 tiles with top-left values 0, 2, 12, 14, in that order.
REQ-032 SHALL check backpressure: tile_ready=0 for 10 cycles after the first tile, and require that pix_ready=0, tile_out is held, and no pixel is lost after release.
REQ-033 SHALL check back-to-back frames on a 6x6 image: the second frame yields identical tiles (top-left 0, 2, 12, 14) and frame_done pulses twice.
REQ-034 SHALL check rst asserted after 20 pixels of a 6x6 frame, then a full frame: only the 4 correct tiles appear and there is no stale data.
REQ-035 SHALL check, with WINO_TILE_CNT_EN on a 16x16 image, 49 tiles with tile_idx running 0..48 and then returning to 0 in the next frame.
